// File: rtl/cordic_pkg.sv
// Shared constants, opcodes and FSM state type for the CORDIC sin/cos unit.
// Angles are radians in Q16.16.
package cordic_pkg;

  localparam logic [3:0] SIN     = 4'b0000;
  localparam logic [3:0] COS     = 4'b0001;
  localparam logic [3:0] ADD     = 4'b0010;
  localparam logic [3:0] SUB     = 4'b0011;
  localparam logic [3:0] MULT    = 4'b0100;
  localparam logic [3:0] DIV     = 4'b0101;
  localparam logic [3:0] DEFAULT = 4'b1111;

  localparam int CORDIC_K = 39797;
  localparam int HALF_PI  = 102944;
  localparam int PI       = 205887;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ROTATE,
    ST_DONE
  } state_t;

  function automatic logic op_ok(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      SIN, COS: ok = 1'b1;
      ADD, SUB, MULT, DIV, DEFAULT: ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/cordic_sincos_unit_if.sv
// Calculator enable/done request bus; master drives the request,
// slave (the CORDIC unit) answers with result/done/busy/op_err.
interface cordic_sincos_unit_if #(
  parameter int WIDTH = 32
);
  logic             enable;
  logic [3:0]       operation;
  logic [WIDTH-1:0] z_in;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             op_err;

  modport master (
    output enable, operation, z_in,
    input  result, done, busy, op_err
  );

  modport slave (
    input  enable, operation, z_in,
    output result, done, busy, op_err
  );
endinterface

// File: rtl/cordic_atan_lut.sv
// Combinational atan(2^-i) table in Q16.16 for the CORDIC rotations.
module cordic_atan_lut #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_idx,
  output logic [WIDTH-1:0] o_atan
);
  always_comb begin
    o_atan = '0;
    case (i_idx)
      4'd0:  o_atan = WIDTH'(51472);
      4'd1:  o_atan = WIDTH'(30386);
      4'd2:  o_atan = WIDTH'(16055);
      4'd3:  o_atan = WIDTH'(8150);
      4'd4:  o_atan = WIDTH'(4091);
      4'd5:  o_atan = WIDTH'(2047);
      4'd6:  o_atan = WIDTH'(1024);
      4'd7:  o_atan = WIDTH'(512);
      4'd8:  o_atan = WIDTH'(256);
      4'd9:  o_atan = WIDTH'(128);
      4'd10: o_atan = WIDTH'(64);
      4'd11: o_atan = WIDTH'(32);
      4'd12: o_atan = WIDTH'(16);
      4'd13: o_atan = WIDTH'(8);
      4'd14: o_atan = WIDTH'(4);
      4'd15: o_atan = WIDTH'(2);
      default: o_atan = '0;
    endcase
  end
endmodule

// File: rtl/cordic_sincos_unit.sv
// Iterative rotation-mode CORDIC sin/cos engine, Q16.16.
// Define CORDIC_QUADRANT_EN to fold |z| > pi/2 into range.
module cordic_sincos_unit #(
  parameter int WIDTH      = 32,
  parameter int ITERATIONS = 16
) (
  input logic             clk,
  input logic             rst,
  cordic_sincos_unit_if.slave bus
);
  import cordic_pkg::*;

  localparam int DW = WIDTH + 2;
  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
  localparam logic signed [DW-1:0] C_K    = DW'(CORDIC_K);
`ifdef CORDIC_QUADRANT_EN
  localparam logic signed [DW-1:0] C_HPI  = DW'(HALF_PI);
  localparam logic signed [DW-1:0] C_NHPI = DW'(-HALF_PI);
  localparam logic signed [DW-1:0] C_PI   = DW'(PI);
`endif

  state_t r_state, w_state_nxt;

  logic [3:0]              r_op;
  logic [3:0]              r_i;
  logic signed [DW-1:0]    r_x, r_y, r_z;
  logic [WIDTH-1:0]        r_result;
  logic                    r_op_err;
`ifdef CORDIC_QUADRANT_EN
  logic                    r_fold;
`endif

  logic                    w_ok;
  logic                    w_d;
  logic [WIDTH-1:0]        w_atan;
  logic signed [DW-1:0]    w_atan_ext;
  logic signed [DW-1:0]    w_shx, w_shy;
  logic signed [DW-1:0]    w_x_nxt, w_y_nxt, w_z_nxt;
  logic [WIDTH-1:0]        w_pick, w_res;
  logic                    w_done, w_busy;

  cordic_atan_lut #(.WIDTH(WIDTH)) u_lut (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  assign w_ok       = op_ok(bus.operation);
  assign w_d        = ~r_z[DW-1];
  assign w_atan_ext = {{2{w_atan[WIDTH-1]}}, w_atan};
  assign w_shx      = r_x >>> r_i;
  assign w_shy      = r_y >>> r_i;
  assign w_x_nxt    = w_d ? r_x - w_shy : r_x + w_shy;
  assign w_y_nxt    = w_d ? r_y + w_shx : r_y - w_shx;
  assign w_z_nxt    = w_d ? r_z - w_atan_ext : r_z + w_atan_ext;

  assign w_pick = (r_op == COS) ? w_x_nxt[WIDTH-1:0]
                                : w_y_nxt[WIDTH-1:0];
`ifdef CORDIC_QUADRANT_EN
  assign w_res = r_fold ? -w_pick : w_pick;
`else
  assign w_res = w_pick;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:
        if (bus.enable)
          w_state_nxt = w_ok ? ST_PREP : ST_DONE;
      ST_PREP:   w_state_nxt = ST_ROTATE;
      ST_ROTATE:
        if (r_i == LAST) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_done = (r_state == ST_DONE);
    w_busy = (r_state != ST_IDLE);
  end

  // result/op_err load on the edge into DONE so they are valid with done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= SIN;
      r_i      <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_result <= '0;
      r_op_err <= 1'b0;
`ifdef CORDIC_QUADRANT_EN
      r_fold   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (bus.enable) begin
            r_op <= bus.operation;
            r_z  <= {{2{bus.z_in[WIDTH-1]}}, bus.z_in};
            if (!w_ok) begin
              r_result <= '0;
              r_op_err <= 1'b1;
            end
          end
        ST_PREP: begin
          r_x <= C_K;
          r_y <= '0;
          r_i <= '0;
`ifdef CORDIC_QUADRANT_EN
          if (r_z > C_HPI) begin
            r_z    <= r_z - C_PI;
            r_fold <= 1'b1;
          end else if (r_z < C_NHPI) begin
            r_z    <= r_z + C_PI;
            r_fold <= 1'b1;
          end else begin
            r_fold <= 1'b0;
          end
`endif
        end
        ST_ROTATE: begin
          r_x <= w_x_nxt;
          r_y <= w_y_nxt;
          r_z <= w_z_nxt;
          r_i <= r_i + 4'd1;
          if (r_i == LAST) begin
            r_result <= w_res;
            r_op_err <= 1'b0;
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.op_err = r_op_err;
  assign bus.done   = w_done;
  assign bus.busy   = w_busy;

endmodule
